// File: rtl/tcm_port_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tcm_port_arb
//  Description : Shares one single-port synchronous TCM SRAM between the core
//                instruction-fetch port and data port. Grants one access per
//                cycle (data first), returns the 1-cycle-latency read data and
//                request tag, and flags out-of-range addresses.
//                Optional build macro TCM_ARB_STARVE_GUARD_EN adds a counter
//                that lets a starved ifetch win after MAX_WAIT denied cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tcm_port_arb #(
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // instruction fetch port
  input  logic              mem_i_rd_i,
  input  logic [31:0]       mem_i_pc_i,
  output logic              mem_i_accept_o,
  output logic              mem_i_valid_o,
  output logic              mem_i_error_o,
  output logic [31:0]       mem_i_inst_o,
  // data port
  input  logic              mem_d_rd_i,
  input  logic [3:0]        mem_d_wr_i,
  input  logic              mem_d_cmo_i,
  input  logic [31:0]       mem_d_addr_i,
  input  logic [31:0]       mem_d_data_wr_i,
  input  logic [10:0]       mem_d_req_tag_i,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic              mem_d_error_o,
  output logic [31:0]       mem_d_data_rd_o,
  output logic [10:0]       mem_d_resp_tag_o,
  // SRAM port
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-3:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic w_d_is_wr;
  logic w_d_req;
  logic w_d_is_rd;
  logic w_i_prio;
  logic w_grant_d;
  logic w_grant_i;
  logic [31:0] w_addr;
  logic w_in_range;
  logic w_sram_op;

  assign w_d_is_wr = |mem_d_wr_i;
  assign w_d_req   = mem_d_rd_i | w_d_is_wr | mem_d_cmo_i;
  // a write with the read flag also set is treated as a write only
  assign w_d_is_rd = mem_d_rd_i & ~w_d_is_wr;

`ifdef TCM_ARB_STARVE_GUARD_EN
  localparam int c_CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [c_CNT_W-1:0] c_WAIT_MAX = c_CNT_W'(MAX_WAIT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [c_CNT_W-1:0] wait_cnt_q;
  logic [c_CNT_W-1:0] wait_cnt_d;

  // Count consecutive cycles a pending ifetch was refused; saturate at the limit
  always_comb begin
    wait_cnt_d = '0;
    if (mem_i_rd_i && !w_grant_i) begin
      wait_cnt_d = (wait_cnt_q == c_WAIT_MAX) ? wait_cnt_q : (wait_cnt_q + c_CNT_ONE);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign w_i_prio = (wait_cnt_q == c_WAIT_MAX);
`else
  assign w_i_prio = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Arbitration: data wins unless a starved ifetch has been promoted.
  // Grants are masked while reset is held so nothing is issued during reset.
  // --------------------------------------------------------------------------
  assign w_grant_d = rst_ni & w_d_req & ~(w_i_prio & mem_i_rd_i);
  assign w_grant_i = rst_ni & mem_i_rd_i & ~w_grant_d;

  assign mem_d_accept_o = w_grant_d;
  assign mem_i_accept_o = w_grant_i;

  assign w_addr     = w_grant_d ? mem_d_addr_i : mem_i_pc_i;
  assign w_in_range = (w_addr[31:ADDR_W] == '0);
  // cache-maintenance ops are acknowledged without touching the SRAM
  assign w_sram_op  = w_grant_i | (w_grant_d & (w_d_is_wr | mem_d_rd_i));

  // Drive the SRAM request for the granted access; idle outputs stay at zero
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 4'b0000;
    ram_addr_o  = '0;
    ram_wdata_o = 32'h0;
    if (w_sram_op && w_in_range) begin
      ram_en_o   = 1'b1;
      ram_addr_o = w_addr[ADDR_W-1:2];
      if (w_grant_d && w_d_is_wr) begin
        ram_we_o    = mem_d_wr_i;
        ram_wdata_o = mem_d_data_wr_i;
      end
    end
  end

  // Byte-offset bits of the address are deliberately ignored
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^w_addr[1:0];

  // --------------------------------------------------------------------------
  // Response slot: one entry, filled on every grant, emitted the next cycle
  // --------------------------------------------------------------------------
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_src_q,   rsp_src_d;     // 1 = data port, 0 = ifetch
  logic        rsp_err_q,   rsp_err_d;
  logic        rsp_rdat_q,  rsp_rdat_d;    // response carries SRAM read data
  logic [10:0] rsp_tag_q,   rsp_tag_d;

  // Capture what the next-cycle response must look like
  always_comb begin
    rsp_valid_d = w_grant_d | w_grant_i;
    rsp_src_d   = w_grant_d;
    rsp_err_d   = (w_grant_d | w_grant_i) & ~w_in_range;
    rsp_rdat_d  = w_in_range & (w_grant_i | (w_grant_d & w_d_is_rd));
    rsp_tag_d   = w_grant_d ? mem_d_req_tag_i : 11'h0;
  end

  // Response slot register; reset drops any pending response
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_src_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdat_q  <= 1'b0;
      rsp_tag_q   <= 11'h0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_src_q   <= rsp_src_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdat_q  <= rsp_rdat_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  // --------------------------------------------------------------------------
  // Response outputs. Held low while reset is asserted so that a response
  // captured in the cycle before reset never reaches the core.
  // --------------------------------------------------------------------------
  logic w_rsp_i;
  logic w_rsp_d;

  assign w_rsp_i = rst_ni & rsp_valid_q & ~rsp_src_q;
  assign w_rsp_d = rst_ni & rsp_valid_q &  rsp_src_q;

  // Route read data straight from the SRAM to whichever port owns the slot
  always_comb begin
    mem_i_valid_o    = w_rsp_i;
    mem_i_error_o    = w_rsp_i & rsp_err_q;
    mem_i_inst_o     = (w_rsp_i & rsp_rdat_q) ? ram_rdata_i : 32'h0;
    mem_d_ack_o      = w_rsp_d;
    mem_d_error_o    = w_rsp_d & rsp_err_q;
    mem_d_data_rd_o  = (w_rsp_d & rsp_rdat_q) ? ram_rdata_i : 32'h0;
    mem_d_resp_tag_o = w_rsp_d ? rsp_tag_q : 11'h0;
  end

endmodule
`default_nettype wire
